// File: rtl/l1_dcache_req_fsm.sv
// L1 data-cache request sequencer: translation, dcache request, and load-response tracking.
// Optional watchdog abort is enabled by defining L1_DCACHE_REQ_WATCHDOG_EN.
module l1_dcache_req_fsm (
    input  logic clk,
    input  logic rst,
    input  logic ldst_valid_i,
    input  logic ldst_is_store_i,
    input  logic dtlb_hit_i,
    input  logic dtlb_exc_i,
    input  logic dcache_req_ready_i,
    input  logic dcache_rsp_valid_i,
    input  logic flush_i,
    output logic translation_req_o,
    output logic trns_ena_o,
    output logic mem_req_valid_o,
    output logic str_rdy_o,
    output logic busy_o,
    output logic is_store_o,
    output logic done_o,
    output logic exc_o,
    output logic timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        XLATE,
        REQ,
        WAIT_RSP,
        DRAIN
    } state_t;

    state_t state;
    state_t nxt;
    logic   done_nxt;
    logic   exc_nxt;
    logic   to_nxt;

`ifdef L1_DCACHE_REQ_WATCHDOG_EN
    logic [7:0] wd_cnt;
    logic       wd_counting;

    assign wd_counting = (state == REQ) || (state == WAIT_RSP) || (state == DRAIN);
`endif

    always_comb begin
        nxt      = state;
        done_nxt = 1'b0;
        exc_nxt  = 1'b0;
        to_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ldst_valid_i && !flush_i)
                    nxt = XLATE;
            end
            XLATE: begin
                if (flush_i) begin
                    nxt = IDLE;
                end else if (dtlb_exc_i) begin
                    nxt     = IDLE;
                    exc_nxt = 1'b1;
                end else if (dtlb_hit_i) begin
                    nxt = REQ;
                end
            end
            REQ: begin
                if (flush_i) begin
                    nxt = IDLE;
                end else if (dcache_req_ready_i) begin
                    if (is_store_o) begin
                        nxt      = IDLE;
                        done_nxt = 1'b1;
                    end else begin
                        nxt = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                // A killed load still owes the dcache its response, so drain it.
                if (flush_i) begin
                    nxt = dcache_rsp_valid_i ? IDLE : DRAIN;
                end else if (dcache_rsp_valid_i) begin
                    nxt      = IDLE;
                    done_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (dcache_rsp_valid_i)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
`ifdef L1_DCACHE_REQ_WATCHDOG_EN
        if (wd_counting && (wd_cnt == 8'hFF)) begin
            nxt      = IDLE;
            done_nxt = 1'b0;
            to_nxt   = 1'b1;
        end
`endif
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            translation_req_o <= 1'b0;
            trns_ena_o        <= 1'b0;
            mem_req_valid_o   <= 1'b0;
            str_rdy_o         <= 1'b0;
            busy_o            <= 1'b0;
            is_store_o        <= 1'b0;
            done_o            <= 1'b0;
            exc_o             <= 1'b0;
        end else begin
            state             <= nxt;
            translation_req_o <= (nxt == XLATE);
            trns_ena_o        <= (nxt == XLATE);
            mem_req_valid_o   <= (nxt == REQ);
            str_rdy_o         <= (nxt == REQ) || (nxt == WAIT_RSP) || (nxt == DRAIN);
            busy_o            <= (nxt != IDLE);
            done_o            <= done_nxt;
            exc_o             <= exc_nxt;
            if ((state == IDLE) && (nxt == XLATE))
                is_store_o <= ldst_is_store_i;
        end
    end

`ifdef L1_DCACHE_REQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= to_nxt;
            if (nxt != state)
                wd_cnt <= '0;
            else if (wd_counting)
                wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_l1_dcache_req_fsm.sv
// Directed scoreboard bench for l1_dcache_req_fsm; follows L1_DCACHE_REQ_WATCHDOG_EN if defined.
module tb_l1_dcache_req_fsm;

    logic clk = 1'b0;
    logic rst;
    logic ldst_valid_i, ldst_is_store_i, dtlb_hit_i, dtlb_exc_i;
    logic dcache_req_ready_i, dcache_rsp_valid_i, flush_i;
    logic translation_req_o, trns_ena_o, mem_req_valid_o, str_rdy_o;
    logic busy_o, is_store_o, done_o, exc_o, timeout_o;
    logic [8:0] outs;

    l1_dcache_req_fsm dut (
        .clk                (clk),
        .rst                (rst),
        .ldst_valid_i       (ldst_valid_i),
        .ldst_is_store_i    (ldst_is_store_i),
        .dtlb_hit_i         (dtlb_hit_i),
        .dtlb_exc_i         (dtlb_exc_i),
        .dcache_req_ready_i (dcache_req_ready_i),
        .dcache_rsp_valid_i (dcache_rsp_valid_i),
        .flush_i            (flush_i),
        .translation_req_o  (translation_req_o),
        .trns_ena_o         (trns_ena_o),
        .mem_req_valid_o    (mem_req_valid_o),
        .str_rdy_o          (str_rdy_o),
        .busy_o             (busy_o),
        .is_store_o         (is_store_o),
        .done_o             (done_o),
        .exc_o              (exc_o),
        .timeout_o          (timeout_o)
    );

    assign outs = {translation_req_o, trns_ena_o, mem_req_valid_o, str_rdy_o,
                   busy_o, is_store_o, done_o, exc_o, timeout_o};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] kind;   // {timeout, exc, done}
        int         cyc;
    } pulse_t;

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_EXC  = 3'b010;
    localparam logic [2:0] K_TO   = 3'b100;

    pulse_t expq[$];
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     busy_cnt, mreq_cnt, wait_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every completion/fault/timeout pulse must match the head of the queue.
    always @(negedge clk) begin
        pulse_t e;
        busy_cnt += int'(busy_o);
        mreq_cnt += int'(mem_req_valid_o);
        wait_cnt += int'(str_rdy_o && !mem_req_valid_o && busy_o);
        if (done_o || exc_o || timeout_o) begin
            checks++;
            if (expq.size() == 0) begin
                assert ({timeout_o, exc_o, done_o} === 3'b000) else begin
                    errors++;
                    $error("FAIL unexpected_pulse: observed %b at cycle %0d required none",
                           {timeout_o, exc_o, done_o}, cyc);
                end
            end else begin
                e = expq.pop_front();
                assert ({timeout_o, exc_o, done_o, cyc} === {e.kind, e.cyc}) else begin
                    errors++;
                    $error("FAIL pulse: observed %b at cycle %0d required %b at cycle %0d",
                           {timeout_o, exc_o, done_o}, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input logic [2:0] k, input int at);
        expq.push_back('{kind: k, cyc: at});
    endtask

    task automatic clr_cnt();
        busy_cnt = 0;
        mreq_cnt = 0;
        wait_cnt = 0;
    endtask

    task automatic issue(input logic st);
        ldst_valid_i    = 1'b1;
        ldst_is_store_i = st;
        tick();
        ldst_valid_i    = 1'b0;
    endtask

    // Issue a load and walk it into WAIT_RSP.
    task automatic load_to_wait();
        issue(1'b0);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        dcache_req_ready_i = 1'b1;
        tick();
        dcache_req_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ldst_valid_i = 0; ldst_is_store_i = 0; dtlb_hit_i = 0; dtlb_exc_i = 0;
        dcache_req_ready_i = 0; dcache_rsp_valid_i = 0; flush_i = 0;
        clr_cnt();
        #12;
        chk("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Load: hit in 3rd XLATE cycle, ready in 2nd REQ cycle, rsp in 3rd WAIT_RSP cycle.
        clr_cnt();
        issue(1'b0);
        chk("ld_xlate", 32'({translation_req_o, trns_ena_o, busy_o, mem_req_valid_o}), 32'b1110);
        tick(2);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        chk("ld_req", 32'({mem_req_valid_o, str_rdy_o, busy_o, translation_req_o}), 32'b1110);
        tick();
        dcache_req_ready_i = 1'b1;
        tick();
        dcache_req_ready_i = 1'b0;
        chk("ld_wait", 32'({mem_req_valid_o, str_rdy_o, busy_o}), 32'b011);
        tick(2);
        dcache_rsp_valid_i = 1'b1;
        expect_pulse(K_DONE, cyc + 1);
        tick();
        dcache_rsp_valid_i = 1'b0;
        chk("ld_idle", 32'(busy_o), 32'd0);
        tick();
        chk("ld_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("ld_pending", 32'(expq.size()), 32'd0);

        // Store with ready withheld for 4 REQ cycles.
        clr_cnt();
        issue(1'b1);
        chk("st_is_store", 32'(is_store_o), 32'd1);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        tick(4);
        chk("st_req_held", 32'(mem_req_valid_o), 32'd1);
        dcache_req_ready_i = 1'b1;
        expect_pulse(K_DONE, cyc + 1);
        tick();
        dcache_req_ready_i = 1'b0;
        tick();
        chk("st_mreq_cycles", 32'(mreq_cnt), 32'd5);
        chk("st_no_wait", 32'(wait_cnt), 32'd0);
        chk("st_pending", 32'(expq.size()), 32'd0);

        // Fault wins over hit; a valid pulse while busy is ignored.
        clr_cnt();
        issue(1'b0);
        ldst_valid_i = 1'b1; ldst_is_store_i = 1'b1;
        dtlb_exc_i = 1'b1; dtlb_hit_i = 1'b1;
        expect_pulse(K_EXC, cyc + 1);
        tick();
        ldst_valid_i = 1'b0; dtlb_exc_i = 1'b0; dtlb_hit_i = 1'b0;
        chk("flt_idle", 32'(busy_o), 32'd0);
        chk("flt_is_store", 32'(is_store_o), 32'd0);
        tick();
        chk("flt_no_mreq", 32'(mreq_cnt), 32'd0);
        chk("flt_pending", 32'(expq.size()), 32'd0);

        // Valid coincident with flush in IDLE is dropped.
        ldst_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        ldst_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_drop", 32'(busy_o), 32'd0);

        // Flush wins over hit in XLATE and over ready in REQ.
        issue(1'b0);
        flush_i = 1'b1; dtlb_hit_i = 1'b1;
        tick();
        flush_i = 1'b0; dtlb_hit_i = 1'b0;
        chk("flush_xlate", 32'(outs), 32'd0);
        tick();
        issue(1'b1);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        flush_i = 1'b1; dcache_req_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; dcache_req_ready_i = 1'b0;
        chk("flush_req", 32'({mem_req_valid_o, str_rdy_o, busy_o}), 32'd0);
        tick();

        // Flush in WAIT_RSP drains until the response, then accepts the next op.
        load_to_wait();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("drain_outs", 32'({str_rdy_o, busy_o, mem_req_valid_o}), 32'b110);
        tick(2);
        chk("drain_held", 32'({str_rdy_o, busy_o}), 32'b11);
        dcache_rsp_valid_i = 1'b1;
        tick();
        dcache_rsp_valid_i = 1'b0;
        chk("drain_exit", 32'(busy_o), 32'd0);
        tick();
        issue(1'b1);
        chk("drain_next_accept", 32'({translation_req_o, busy_o}), 32'b11);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        dcache_req_ready_i = 1'b1;
        expect_pulse(K_DONE, cyc + 1);
        tick();
        dcache_req_ready_i = 1'b0;
        tick();
        chk("drain_pending", 32'(expq.size()), 32'd0);

        // Flush coincident with response in WAIT_RSP: straight to IDLE, no done.
        load_to_wait();
        flush_i = 1'b1; dcache_rsp_valid_i = 1'b1;
        tick();
        flush_i = 1'b0; dcache_rsp_valid_i = 1'b0;
        chk("flush_rsp_idle", 32'(busy_o), 32'd0);
        tick();

        // Response withheld in WAIT_RSP.
        load_to_wait();
`ifdef L1_DCACHE_REQ_WATCHDOG_EN
        expect_pulse(K_TO, cyc + 256);
        tick(256);
        chk("wd_idle", 32'(busy_o), 32'd0);
        tick();
        chk("wd_pending", 32'(expq.size()), 32'd0);
`else
        tick(300);
        chk("nowd_busy", 32'({busy_o, str_rdy_o}), 32'b11);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        dcache_rsp_valid_i = 1'b1;
        tick();
        dcache_rsp_valid_i = 1'b0;
        chk("nowd_exit", 32'(busy_o), 32'd0);
        tick();
`endif

        // Asynchronous reset in REQ between clock edges.
        issue(1'b1);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy_o), 32'd0);
        issue(1'b1);
        dtlb_hit_i = 1'b1;
        tick();
        dtlb_hit_i = 1'b0;
        dcache_req_ready_i = 1'b1;
        expect_pulse(K_DONE, cyc + 1);
        tick();
        dcache_req_ready_i = 1'b0;
        tick();
        chk("post_rst_pending", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
